// File: rtl/outstream_check.sv
// outstream_check: output-stream sink and checker for core-complex benches.
// Accepts values from one core-complex output port over the read handshake.
// Each value is compared against a run-time expected list. The block counts
// accepted and matching values, latches the first mismatch, and reports
// done/pass.
// Optional feature: define OUTSTREAM_CHECK_TIMEOUT_EN to build an idle
// watchdog. The watchdog ends a run after TIMEOUT consecutive cycles in RUN
// without a transfer.
module outstream_check #(
   parameter int WIDTH       = 11,
   parameter int DEPTH       = 64,
   parameter int LW          = $clog2(DEPTH + 1),
   parameter int STOP_ON_ERR = 0,
   parameter int TIMEOUT     = 1024
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LW-1:0]    length,
   input  logic [WIDTH-1:0] expected [0:DEPTH-1],
   input  logic             rready,
   input  logic [WIDTH-1:0] in,
   output logic             read,
   output logic [LW-1:0]    count,
   output logic [LW-1:0]    correct,
   output logic [LW-1:0]    err_idx,
   output logic [WIDTH-1:0] err_val,
   output logic             err,
   output logic             done,
   output logic             pass,
   output logic             timed_out
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_reg, state_next;
   logic [LW-1:0]    len_reg, len_next;
   logic [LW-1:0]    count_reg, count_next;
   logic [LW-1:0]    correct_reg, correct_next;
   logic [LW-1:0]    err_idx_reg, err_idx_next;
   logic [WIDTH-1:0] err_val_reg, err_val_next;
   logic             err_reg, err_next;

   logic [LW-1:0]    len_clamped;
   logic [WIDTH-1:0] exp_sel;
   logic [WIDTH-1:0] exp_masked [0:DEPTH-1];
   logic             xfer;
   logic             match;
   logic             last;

   // An over-long list is a usage error; never run past the end of the list.
   assign len_clamped = (length > LW'(DEPTH)) ? LW'(DEPTH) : length;

   // Select expected[count] as an AND-OR mux.
   // count reaches DEPTH only outside RUN, where an all-zero selection is harmless.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_sel
         assign exp_masked[gi] = (count_reg == LW'(gi)) ? expected[gi] : '0;
      end
   endgenerate

   // OR-reduce the masked entries into the currently expected value.
   always_comb begin
      exp_sel = '0;
      for (int i = 0; i < DEPTH; i++) begin
         exp_sel = exp_sel | exp_masked[i];
      end
   end

   assign xfer  = rready && (state_reg == ST_RUN);
   assign match = (in == exp_sel);
   // In RUN, count < len <= DEPTH, so this addition cannot overflow LW bits.
   assign last  = ((count_reg + LW'(1)) == len_reg);

`ifdef OUTSTREAM_CHECK_TIMEOUT_EN
   localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

   logic [TW-1:0] idle_reg, idle_next;
   logic          tout_reg, tout_next;
`else
   // TIMEOUT only matters when the watchdog is built.
   // This empty block keeps the parameter referenced in the default build.
   generate
      if (TIMEOUT < 1) begin : g_timeout_unused
      end
   endgenerate
`endif

   // Next-state and next-result logic for the IDLE/RUN/DONE run controller.
   always_comb begin
      state_next   = state_reg;
      len_next     = len_reg;
      count_next   = count_reg;
      correct_next = correct_reg;
      err_idx_next = err_idx_reg;
      err_val_next = err_val_reg;
      err_next     = err_reg;
`ifdef OUTSTREAM_CHECK_TIMEOUT_EN
      idle_next    = idle_reg;
      tout_next    = tout_reg;
`endif
      case (state_reg)
         ST_IDLE, ST_DONE: begin
            // start wins over a simultaneous rready; read is 0 here anyway.
            if (start) begin
               len_next     = len_clamped;
               count_next   = '0;
               correct_next = '0;
               err_idx_next = '0;
               err_val_next = '0;
               err_next     = 1'b0;
`ifdef OUTSTREAM_CHECK_TIMEOUT_EN
               idle_next    = '0;
               tout_next    = 1'b0;
`endif
               state_next   = (len_clamped == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (xfer) begin
               count_next = count_reg + LW'(1);
               if (match) begin
                  correct_next = correct_reg + LW'(1);
               end else if (!err_reg) begin
                  err_next     = 1'b1;
                  err_idx_next = count_reg;
                  err_val_next = in;
               end
`ifdef OUTSTREAM_CHECK_TIMEOUT_EN
               idle_next = '0;
`endif
               if (last || ((STOP_ON_ERR != 0) && !match)) begin
                  state_next = ST_DONE;
               end
            end
`ifdef OUTSTREAM_CHECK_TIMEOUT_EN
            else if (idle_reg == TW'(TIMEOUT - 1)) begin
               tout_next  = 1'b1;
               state_next = ST_DONE;
            end else begin
               idle_next = idle_reg + TW'(1);
            end
`endif
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // State and result registers; reset abandons any run in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= ST_IDLE;
         len_reg     <= '0;
         count_reg   <= '0;
         correct_reg <= '0;
         err_idx_reg <= '0;
         err_val_reg <= '0;
         err_reg     <= 1'b0;
      end else begin
         state_reg   <= state_next;
         len_reg     <= len_next;
         count_reg   <= count_next;
         correct_reg <= correct_next;
         err_idx_reg <= err_idx_next;
         err_val_reg <= err_val_next;
         err_reg     <= err_next;
      end
   end

`ifdef OUTSTREAM_CHECK_TIMEOUT_EN
   // Watchdog registers: consecutive idle cycles in RUN and the fired flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idle_reg <= '0;
         tout_reg <= 1'b0;
      end else begin
         idle_reg <= idle_next;
         tout_reg <= tout_next;
      end
   end

   assign timed_out = tout_reg;
`else
   assign timed_out = 1'b0;
`endif

   assign read    = (state_reg == ST_RUN);
   assign done    = (state_reg == ST_DONE);
   assign count   = count_reg;
   assign correct = correct_reg;
   assign err_idx = err_idx_reg;
   assign err_val = err_val_reg;
   assign err     = err_reg;
   assign pass    = done && !err_reg && !timed_out && (count_reg == len_reg);

endmodule

// File: tb/tb_outstream_check.sv
// Bench for outstream_check.
// It drives one main instance (STOP_ON_ERR=0) and one stop-on-error instance
// from shared inputs. Per-transfer expectations are queued when a value is
// driven, then popped and compared after the DUT accepts it.
module tb_outstream_check;
   localparam int WIDTH = 11;
   localparam int DEPTH = 64;
   localparam int LW    = $clog2(DEPTH + 1);
   localparam int TOUT  = 16;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic             rready = 1'b0;
   logic [LW-1:0]    length = '0;
   logic [WIDTH-1:0] in = '0;
   logic [WIDTH-1:0] expected [0:DEPTH-1];

   logic             read, err, done, pass, timed_out;
   logic [LW-1:0]    count, correct, err_idx;
   logic [WIDTH-1:0] err_val;
   logic             read_s, err_s, done_s, pass_s, timed_out_s;
   logic [LW-1:0]    count_s, correct_s, err_idx_s;
   logic [WIDTH-1:0] err_val_s;

   outstream_check #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STOP_ON_ERR(0), .TIMEOUT(TOUT)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .length(length), .expected(expected),
      .rready(rready), .in(in), .read(read), .count(count), .correct(correct),
      .err_idx(err_idx), .err_val(err_val), .err(err), .done(done), .pass(pass),
      .timed_out(timed_out));

   outstream_check #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STOP_ON_ERR(1), .TIMEOUT(TOUT)) dut_s (
      .clk(clk), .rst_n(rst_n), .start(start), .length(length), .expected(expected),
      .rready(rready), .in(in), .read(read_s), .count(count_s), .correct(correct_s),
      .err_idx(err_idx_s), .err_val(err_val_s), .err(err_s), .done(done_s), .pass(pass_s),
      .timed_out(timed_out_s));

   always #5 clk = ~clk;

   typedef struct {
      int cnt;
      int cor;
   } sb_t;

   sb_t sbq[$];
   int  errors = 0;
   int  checks = 0;
   int  m_count = 0;
   int  m_correct = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      m_count   = 0;
      m_correct = 0;
      sbq.delete();
   endtask

   task automatic start_run(input int len);
      length = LW'(len);
      start  = 1'b1;
      tick();
      start  = 1'b0;
      model_clear();
      $display("start len=%0d", len);
   endtask

   // Drive one value, wait (bounded) for it to be accepted, then score it.
   task automatic xfer(input logic [WIDTH-1:0] v);
      logic ok;
      bit   got;
      sb_t  e;
      sb_t  o;
      got   = 1'b0;
      e.cnt = m_count + 1;
      e.cor = m_correct + ((v == expected[m_count]) ? 1 : 0);
      sbq.push_back(e);
      m_count   = e.cnt;
      m_correct = e.cor;
      in     = v;
      rready = 1'b1;
      for (int t = 0; t < 32; t++) begin
         ok = read;
         tick();
         if (ok) begin
            got = 1'b1;
            break;
         end
      end
      check("xfer_accepted", {31'b0, got}, 32'd1);
      o = sbq.pop_front();
      check("xfer_count", 32'(count), 32'(o.cnt));
      check("xfer_correct", 32'(correct), 32'(o.cor));
      $display("xfer in=%03h count=%0d correct=%0d", v, count, correct);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      for (int i = 0; i < DEPTH; i++) expected[i] = WIDTH'(i);

      // Reset state.
      tick();
      tick();
      check("rst_read", {31'b0, read}, 0);
      check("rst_count", 32'(count), 0);
      check("rst_done", {31'b0, done}, 0);
      check("rst_pass", {31'b0, pass}, 0);
      check("rst_timed_out", {31'b0, timed_out}, 0);
      rst_n = 1'b1;

      // rready in IDLE is ignored.
      rready = 1'b1;
      tick();
      tick();
      check("idle_read", {31'b0, read}, 0);
      check("idle_count", 32'(count), 0);
      rready = 1'b0;

      // Clean run of 5 values.
      start_run(5);
      check("run_read", {31'b0, read}, 1);
      for (int i = 0; i < 5; i++) begin
         xfer(WIDTH'(i));
         if (i == 3) check("done_early", {31'b0, done}, 0);
      end
      rready = 1'b0;
      check("t1_done", {31'b0, done}, 1);
      check("t1_pass", {31'b0, pass}, 1);
      check("t1_err", {31'b0, err}, 0);
      check("t1_read", {31'b0, read}, 0);

      // Mismatch at index 2, with and without stop-on-error.
      start_run(5);
      for (int i = 0; i < 5; i++) begin
         xfer((i == 2) ? WIDTH'(7) : WIDTH'(i));
         if (i == 2) begin
            check("stop_done", {31'b0, done_s}, 1);
            check("stop_count", 32'(count_s), 3);
            check("stop_correct", 32'(correct_s), 2);
            check("stop_read", {31'b0, read_s}, 0);
            check("stop_err_idx", 32'(err_idx_s), 2);
         end
      end
      rready = 1'b0;
      check("t2_done", {31'b0, done}, 1);
      check("t2_err", {31'b0, err}, 1);
      check("t2_err_idx", 32'(err_idx), 2);
      check("t2_err_val", 32'(err_val), 7);
      check("t2_pass", {31'b0, pass}, 0);
      check("t2_stop_read_after", {31'b0, read_s}, 0);
      check("t2_stop_count_after", 32'(count_s), 3);

      // Negative data; start and rready together in DONE: start wins.
      expected[0] = 11'h419;
      expected[1] = 11'h3E7;
      length = LW'(2);
      in     = 11'h419;
      rready = 1'b1;
      start  = 1'b1;
      tick();
      start = 1'b0;
      model_clear();
      check("start_wins_count", 32'(count), 0);
      check("start_wins_read", {31'b0, read}, 1);
      xfer(11'h419);
      xfer(11'h3E7);
      rready = 1'b0;
      check("neg_correct", 32'(correct), 2);
      check("neg_pass", {31'b0, pass}, 1);

      // Zero-length run.
      start_run(0);
      check("len0_done", {31'b0, done}, 1);
      check("len0_pass", {31'b0, pass}, 1);
      check("len0_read", {31'b0, read}, 0);

      // Asynchronous reset mid-run.
      for (int i = 0; i < DEPTH; i++) expected[i] = WIDTH'(i);
      start_run(5);
      xfer(WIDTH'(0));
      xfer(WIDTH'(9));
      rready = 1'b0;
      check("pre_rst_err", {31'b0, err}, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_count", 32'(count), 0);
      check("arst_correct", 32'(correct), 0);
      check("arst_err", {31'b0, err}, 0);
      check("arst_err_idx", 32'(err_idx), 0);
      check("arst_err_val", 32'(err_val), 0);
      check("arst_read", {31'b0, read}, 0);
      tick();
      rst_n = 1'b1;
      tick();
      check("post_rst_read", {31'b0, read}, 0);
      check("post_rst_done", {31'b0, done}, 0);
      start_run(5);
      check("restart_count", 32'(count), 0);
      for (int i = 0; i < 5; i++) xfer(WIDTH'(i));
      rready = 1'b0;
      check("restart_pass", {31'b0, pass}, 1);

      // Over-long length is clamped to DEPTH.
      start_run(100);
      for (int i = 0; i < DEPTH; i++) xfer(WIDTH'(i));
      rready = 1'b0;
      check("clamp_done", {31'b0, done}, 1);
      check("clamp_count", 32'(count), DEPTH);
      check("clamp_pass", {31'b0, pass}, 1);

`ifdef OUTSTREAM_CHECK_TIMEOUT_EN
      // Producer stalls after one value; watchdog ends the run.
      start_run(3);
      xfer(WIDTH'(0));
      rready = 1'b0;
      n = 0;
      while (!done && n < 40) begin
         tick();
         n++;
      end
      check("tout_cycles", 32'(n), TOUT);
      check("tout_flag", {31'b0, timed_out}, 1);
      check("tout_count", 32'(count), 1);
      check("tout_pass", {31'b0, pass}, 0);
      start_run(0);
      check("tout_cleared", {31'b0, timed_out}, 0);
`else
      // Without the watchdog a stalled producer leaves the block in RUN.
      start_run(3);
      xfer(WIDTH'(0));
      rready = 1'b0;
      n = 0;
      repeat (40) begin
         tick();
         n++;
      end
      check("stall_done", {31'b0, done}, 0);
      check("stall_read", {31'b0, read}, 1);
      check("stall_timed_out", {31'b0, timed_out}, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
